// File: rtl/ipml_fifo_wr_arb.sv
// Round-robin arbiter sharing one prefetch FIFO write port among c_NUM_REQ valid/ready requesters.
// Define ARB_TAG_EN to prepend grant_id to fifo_wr_data so the reader can demultiplex sources.
module ipml_fifo_wr_arb #(
  parameter int c_NUM_REQ    = 4,
  parameter int c_DATA_WIDTH = 32,
  parameter int c_MAX_BURST  = 16,
  parameter int c_ID_WIDTH   = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [c_NUM_REQ-1:0]              req_valid,
  input  logic [c_NUM_REQ-1:0]              req_last,
  input  logic [c_NUM_REQ*c_DATA_WIDTH-1:0] req_data,
  output logic [c_NUM_REQ-1:0]              req_ready,
  input  logic                              fifo_wr_vld,
  output logic                              fifo_wr_en,
`ifdef ARB_TAG_EN
  output logic [c_ID_WIDTH+c_DATA_WIDTH-1:0] fifo_wr_data,
`else
  output logic [c_DATA_WIDTH-1:0]            fifo_wr_data,
`endif
  output logic [c_ID_WIDTH-1:0]             grant_id,
  output logic                              busy
);

  localparam int c_CNT_WIDTH = $clog2(c_MAX_BURST + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  logic [0:0]              state;
  logic [c_ID_WIDTH-1:0]   rr_ptr;
  logic [c_CNT_WIDTH-1:0]  beat_cnt;
  logic                    any_valid;
  logic [c_ID_WIDTH-1:0]   winner;
  logic                    owner_valid;
  logic                    owner_last;
  logic [c_DATA_WIDTH-1:0] owner_data;
  logic                    accept;
  logic                    release_burst;

  // Descending scan so the candidate nearest to rr_ptr+1 is the last one written.
  always_comb begin
    any_valid = 1'b0;
    winner    = '0;
    for (int k = c_NUM_REQ; k >= 1; k--) begin
      if (req_valid[c_ID_WIDTH'((int'(rr_ptr) + k) % c_NUM_REQ)]) begin
        any_valid = 1'b1;
        winner    = c_ID_WIDTH'((int'(rr_ptr) + k) % c_NUM_REQ);
      end
    end
  end

  always_comb begin
    owner_valid   = req_valid[grant_id];
    owner_last    = req_last[grant_id];
    owner_data    = req_data[int'(grant_id)*c_DATA_WIDTH +: c_DATA_WIDTH];
    busy          = (state == ST_LOCK);
    accept        = busy & owner_valid & fifo_wr_vld;
    release_burst = accept & (owner_last | (beat_cnt == c_CNT_WIDTH'(c_MAX_BURST - 1)));
    fifo_wr_en    = accept;
    req_ready     = (busy & fifo_wr_vld) ? (c_NUM_REQ'(1) << grant_id) : '0;
`ifdef ARB_TAG_EN
    fifo_wr_data  = accept ? {grant_id, owner_data} : '0;
`else
    fifo_wr_data  = accept ? owner_data : '0;
`endif
  end

  // Leaving LOCK always passes through IDLE, which gives the mandatory one-cycle bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      rr_ptr   <= c_ID_WIDTH'(c_NUM_REQ - 1);
      beat_cnt <= '0;
      grant_id <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_valid) begin
            grant_id <= winner;
            rr_ptr   <= winner;
            state    <= ST_LOCK;
          end
        end
        ST_LOCK: begin
          if (release_burst) begin
            beat_cnt <= '0;
            state    <= ST_IDLE;
          end else if (accept) begin
            beat_cnt <= beat_cnt + c_CNT_WIDTH'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ipml_fifo_wr_arb.sv
// Directed bench for ipml_fifo_wr_arb: requester models feed planned bursts, a scoreboard checks FIFO writes.
module tb_ipml_fifo_wr_arb;

  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int MAXB = 16;
  localparam int IDW  = 2;
`ifdef ARB_TAG_EN
  localparam int OW = IDW + DW;
`else
  localparam int OW = DW;
`endif

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_last;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              fifo_wr_vld;
  logic              fifo_wr_en;
  logic [OW-1:0]     fifo_wr_data;
  logic [IDW-1:0]    grant_id;
  logic              busy;

  typedef struct {
    logic [IDW-1:0] id;
    logic [DW-1:0]  data;
  } beat_t;

  beat_t sb[$];
  int total = 0;
  int bad   = 0;

  int          cnt[NREQ];
  int          len[NREQ];
  int          blen[NREQ];
  logic [DW-1:0] base[NREQ];

  ipml_fifo_wr_arb #(
    .c_NUM_REQ(NREQ), .c_DATA_WIDTH(DW), .c_MAX_BURST(MAXB), .c_ID_WIDTH(IDW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .fifo_wr_vld(fifo_wr_vld),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .grant_id(grant_id),
    .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [OW-1:0] expWord(input beat_t b);
`ifdef ARB_TAG_EN
    return {b.id, b.data};
`else
    return b.data;
`endif
  endfunction

  task automatic pushExp(input int id, input logic [DW-1:0] d);
    beat_t b;
    b.id   = IDW'(id);
    b.data = d;
    sb.push_back(b);
  endtask

  // Requester model: valid while beats remain, last every blen beats and on the final beat.
  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = (cnt[i] < len[i]);
      req_last[i]  = (cnt[i] < len[i]) &&
                     ((cnt[i] + 1 == len[i]) || (blen[i] != 0 && ((cnt[i] + 1) % blen[i]) == 0));
      req_data[i*DW +: DW] = base[i] + DW'(cnt[i]);
    end
  endtask

  task automatic tick();
    logic [NREQ-1:0] acc;
    @(negedge clk);
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) if (acc[i]) cnt[i]++;
    drive();
  endtask

  task automatic applyStimulus(input int i, input int beats, input int burst);
    len[i]  = cnt[i] + beats;
    blen[i] = burst;
    drive();
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor: every FIFO write must match the next planned beat.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (fifo_wr_en === 1'b1) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL beat_unexpected: got write %0h expected no write at %0t", fifo_wr_data, $time);
        end else begin
          e = sb.pop_front();
          checkOutput("beat_id", 64'(grant_id), 64'(e.id));
          checkOutput("beat_data", 64'(fifo_wr_data), 64'(expWord(e)));
        end
      end else begin
        checkOutput("idle_data_zero", 64'(fifo_wr_data), 64'd0);
      end
    end
  end

  initial begin
    int s0, s1, s2, s3;
    logic [OW-1:0] tag_exp;
    base[0] = 32'h1100_0000;
    base[1] = 32'h2200_0000;
    base[2] = 32'h3300_0000;
    base[3] = 32'h4400_0000;
    for (int i = 0; i < NREQ; i++) begin
      cnt[i] = 0; len[i] = 0; blen[i] = 0;
    end
    rst_n = 1'b0;
    fifo_wr_vld = 1'b1;
    drive();
    tick();
    tick();
    #1;
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_grant", 64'(grant_id), 64'd0);
    checkOutput("rst_ready", 64'(req_ready), 64'd0);
    checkOutput("rst_wr_en", 64'(fifo_wr_en), 64'd0);
    checkOutput("rst_wr_data", 64'(fifo_wr_data), 64'd0);
    rst_n = 1'b1;

    // Test 1: single requester, 3-beat burst
    $display("[TB] test 1: single 3-beat burst");
    applyStimulus(0, 3, 0);
    for (int k = 0; k < 3; k++) pushExp(0, base[0] + DW'(k));
    for (int c = 0; c <= 4; c++) begin
      if (c > 0) tick();
      #1;
      checkOutput("t1_busy", 64'(busy), 64'(c >= 1 && c <= 3));
      checkOutput("t1_wr_en", 64'(fifo_wr_en), 64'(c >= 1 && c <= 3));
      if (c == 1) checkOutput("t1_grant", 64'(grant_id), 64'd0);
    end

    // Test 2: all four requesters with single-beat bursts
    $display("[TB] test 2: round robin single beats");
    applyReset();
    s0 = cnt[0];
    for (int i = 0; i < NREQ; i++) applyStimulus(i, 2, 1);
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NREQ; i++) pushExp(i, base[i] + DW'((i == 0 ? s0 : 0) + k));
    for (int c = 0; c <= 16; c++) begin
      if (c > 0) tick();
      #1;
      checkOutput("t2_busy", 64'(busy), 64'((c % 2 == 1) && c <= 15));
      if (c % 2 == 1) checkOutput("t2_grant", 64'(grant_id), 64'(((c - 1) / 2) % 4));
    end

    // Test 3: requester 2 streams 40 beats, forced releases interleave requester 1
    $display("[TB] test 3: max burst release");
    s1 = cnt[1];
    s2 = cnt[2];
    applyStimulus(2, 40, 0);
    for (int k = 0; k < 16; k++) pushExp(2, base[2] + DW'(s2 + k));
    pushExp(1, base[1] + DW'(s1));
    pushExp(1, base[1] + DW'(s1 + 1));
    for (int k = 16; k < 32; k++) pushExp(2, base[2] + DW'(s2 + k));
    pushExp(1, base[1] + DW'(s1 + 2));
    pushExp(1, base[1] + DW'(s1 + 3));
    for (int k = 32; k < 40; k++) pushExp(2, base[2] + DW'(s2 + k));
    for (int c = 0; c <= 50; c++) begin
      if (c > 0) tick();
      if (c == 1) applyStimulus(1, 4, 2);
      #1;
      case (c)
        16: begin checkOutput("t3_busy16", 64'(busy), 64'd1); checkOutput("t3_grant16", 64'(grant_id), 64'd2); end
        17: checkOutput("t3_bubble17", 64'(busy), 64'd0);
        18: checkOutput("t3_grant18", 64'(grant_id), 64'd1);
        20: checkOutput("t3_bubble20", 64'(busy), 64'd0);
        21: checkOutput("t3_grant21", 64'(grant_id), 64'd2);
        37: checkOutput("t3_bubble37", 64'(busy), 64'd0);
        38: checkOutput("t3_grant38", 64'(grant_id), 64'd1);
        41: checkOutput("t3_grant41", 64'(grant_id), 64'd2);
        48: checkOutput("t3_busy48", 64'(busy), 64'd1);
        49: checkOutput("t3_idle49", 64'(busy), 64'd0);
        default: ;
      endcase
    end

    // Test 4: FIFO full for 5 cycles mid-burst
    $display("[TB] test 4: backpressure");
    s3 = cnt[3];
    applyStimulus(3, 6, 0);
    for (int k = 0; k < 6; k++) pushExp(3, base[3] + DW'(s3 + k));
    for (int c = 0; c <= 12; c++) begin
      if (c > 0) tick();
      if (c == 3) fifo_wr_vld = 1'b0;
      if (c == 8) fifo_wr_vld = 1'b1;
      #1;
      checkOutput("t4_busy", 64'(busy), 64'(c >= 1 && c <= 11));
      checkOutput("t4_wr_en", 64'(fifo_wr_en), 64'((c >= 1 && c <= 2) || (c >= 8 && c <= 11)));
      if (c >= 3 && c <= 7) checkOutput("t4_ready_stall", 64'(req_ready), 64'd0);
      if (c == 8) checkOutput("t4_ready_resume", 64'(req_ready), 64'h8);
    end

    // Test 5: reset during beat 5 of a 10-beat burst
    $display("[TB] test 5: reset mid-burst");
    s0 = cnt[0];
    s1 = cnt[1];
    applyStimulus(1, 10, 0);
    for (int k = 0; k < 4; k++) pushExp(1, base[1] + DW'(s1 + k));
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1) begin
        #1;
        checkOutput("t5_grant1", 64'(grant_id), 64'd1);
      end
    end
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_busy", 64'(busy), 64'd0);
    checkOutput("t5_rst_wr_en", 64'(fifo_wr_en), 64'd0);
    checkOutput("t5_rst_ready", 64'(req_ready), 64'd0);
    checkOutput("t5_rst_data", 64'(fifo_wr_data), 64'd0);
    checkOutput("t5_rst_grant", 64'(grant_id), 64'd0);
    tick();
    rst_n = 1'b1;
    applyStimulus(0, 2, 0);
    pushExp(0, base[0] + DW'(s0));
    pushExp(0, base[0] + DW'(s0 + 1));
    for (int k = 4; k < 10; k++) pushExp(1, base[1] + DW'(s1 + k));
    for (int c = 6; c <= 17; c++) begin
      if (c > 6) tick();
      #1;
      if (c == 7) begin
        checkOutput("t5_busy7", 64'(busy), 64'd1);
        checkOutput("t5_grant7", 64'(grant_id), 64'd0);
      end
      if (c == 10) checkOutput("t5_grant10", 64'(grant_id), 64'd1);
      if (c == 16) checkOutput("t5_idle16", 64'(busy), 64'd0);
    end

    // Test 6: known pattern from requester 3 for the tag layout
    $display("[TB] test 6: data tag");
    base[3] = 32'hDEADBEEF - DW'(cnt[3]);
    applyStimulus(3, 1, 0);
    pushExp(3, 32'hDEADBEEF);
`ifdef ARB_TAG_EN
    tag_exp = {2'b11, 32'hDEADBEEF};
`else
    tag_exp = 32'hDEADBEEF;
`endif
    tick();
    #1;
    checkOutput("t6_grant", 64'(grant_id), 64'd3);
    checkOutput("t6_wr_data", 64'(fifo_wr_data), 64'(tag_exp));
    tick();
    tick();
    #1;
    checkOutput("t6_idle", 64'(busy), 64'd0);

    tick();
    checkOutput("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
